// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer and mid-bit sampling
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
   state_t state, state_n;
   logic rx_m, rx_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic [7:0] shreg, shreg_n, data_out_n;
   logic dv_n, fe_n;

   assign busy = state != IDLE;

   // synchronizer, FSM state, datapath and registered output pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_m       <= 1'b1;
         rx_s       <= 1'b1;
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_m       <= rx;
         rx_s       <= rx_m;
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= bit_idx_n;
         shreg      <= shreg_n;
         data_out   <= data_out_n;
         data_valid <= dv_n;
         frame_err  <= fe_n;
      end
   end

   // next-state: start detect, mid-bit sampling, stop-bit validation
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      bit_idx_n  = bit_idx;
      shreg_n    = shreg;
      data_out_n = data_out;
      dv_n       = 1'b0;
      fe_n       = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            if (cnt == HALF) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               state_n   = rx_s ? IDLE : DATA;
            end else cnt_n = cnt + 1'b1;
         end
         DATA: begin
            if (cnt == LAST) begin
               cnt_n            = '0;
               shreg_n[bit_idx] = rx_s;
               bit_idx_n        = (bit_idx == 3'd7) ? 3'd0 : bit_idx + 3'd1;
               state_n          = (bit_idx == 3'd7) ? STOP : DATA;
            end else cnt_n = cnt + 1'b1;
         end
         STOP: begin
            if (cnt == LAST) begin
               cnt_n      = '0;
               data_out_n = rx_s ? shreg : data_out;
               dv_n       = rx_s;
               fe_n       = !rx_s;
               state_n    = rx_s ? IDLE : WAIT_IDLE;
            end else cnt_n = cnt + 1'b1;
         end
         WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
         default:   state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a frame-level model
module tb_uart_rx;
   localparam int CPB = 16;
   logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
   logic [7:0] data_out;
   logic data_valid, frame_err, busy;
   int checks = 0, errors = 0;
   int cyc = 0, dv_cnt = 0, fe_cnt = 0, both_cnt = 0, wide_cnt = 0;
   int dv_cyc = 0, fall_cyc = 0;
   int exp_dv = 0, exp_fe = 0;
   logic [7:0] exp_last = 8'h00;
   logic prev_dv = 1'b0, prev_fe = 1'b0;
   logic [7:0] got_q[$];
   logic [7:0] b2b[4];

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx),
      .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // cycle counter for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   // output monitor on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (data_valid) begin
         dv_cnt++;
         dv_cyc = cyc;
         got_q.push_back(data_out);
      end
      if (frame_err) fe_cnt++;
      if (data_valid && frame_err) both_cnt++;
      if ((data_valid && prev_dv) || (frame_err && prev_fe)) wide_cnt++;
      prev_dv = data_valid;
      prev_fe = frame_err;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drive one 8N1 frame starting on a falling clock edge; model expectations follow the stop bit
   task automatic send(input logic [7:0] b, input logic stop);
      fall_cyc = cyc;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      if (stop) begin
         exp_dv++;
         exp_last = b;
      end else exp_fe++;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_data"}, int'(data_out), int'(exp_last));
      chk({tag, "_dv"}, dv_cnt, exp_dv);
      chk({tag, "_fe"}, fe_cnt, exp_fe);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_data", int'(data_out), 0);
      chk("rst_dv", int'(data_valid), 0);
      chk("rst_fe", int'(frame_err), 0);
      chk("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      send(8'hA5, 1'b1);
      #1;
      chk_model("a5");
      chk("a5_busy", int'(busy), 0);
      chk("a5_lat", int'((dv_cyc - fall_cyc) >= 154 && (dv_cyc - fall_cyc) <= 156), 1);
      @(negedge clk);
      repeat (4) @(negedge clk);
      rx = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("glitch_busy_hi", int'(busy), 1);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      chk_model("glitch");
      chk("glitch_busy_lo", int'(busy), 0);
      @(negedge clk);
      send(8'h3C, 1'b0);
      #1;
      chk_model("ferr");
      chk("ferr_busy", int'(busy), 1);
      repeat (40) @(negedge clk);
      #1;
      chk("break_busy", int'(busy), 1);
      chk_model("break");
      rx = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("break_end_busy", int'(busy), 0);
      @(negedge clk);
      send(8'h5A, 1'b1);
      #1;
      chk_model("after_break");
      @(negedge clk);
      repeat (3) @(negedge clk);
      got_q.delete();
      b2b = '{8'h00, 8'hFF, 8'h01, 8'h80};
      for (int i = 0; i < 4; i++) send(b2b[i], 1'b1);
      #1;
      chk("b2b_count", got_q.size(), 4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) chk($sformatf("b2b_%0d", i), int'(got_q[i]), int'(b2b[i]));
      chk_model("b2b");
      @(negedge clk);
      repeat (3) @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = 8'h77 >> i;
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      exp_last = 8'h00;
      chk("midrst_data", int'(data_out), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_dv", int'(data_valid), 0);
      chk("midrst_fe", int'(frame_err), 0);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      chk_model("post_rst");
      @(negedge clk);
      send(8'hC3, 1'b1);
      #1;
      chk_model("c3");
      for (int n = 0; n < 10; n++) begin
         logic [7:0] b;
         logic stop;
         b = 8'($urandom);
         stop = $urandom_range(0, 3) != 0;
         @(negedge clk);
         send(b, stop);
         if (!stop) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            rx = 1'b1;
            repeat (3) @(negedge clk);
         end
         repeat ($urandom_range(0, 5)) @(negedge clk);
         #1;
         chk_model($sformatf("rnd%0d", n));
      end
      chk("never_both", both_cnt, 0);
      chk("pulse_width", wide_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
